// File: rtl/avalon_sdram_responder.sv
// rtl/avalon_sdram_responder.sv - Avalon-MM slave scratch memory with pipelined reads
//
// Word-addressed memory of 2^ADDR_WIDTH words mapped at byte address BASE_ADDR.
// Reads return after READ_LATENCY cycles with a one-cycle readdatavalid pulse,
// strictly in acceptance order. Out-of-range/misaligned reads return 32'hDEADBEEF.
//
// Optional feature macro: AVALON_RESPONDER_WAIT_EN
//   defined   -> WAIT_CYCLES waitrequest cycles are inserted per command
//   undefined -> slave_waitrequest tied to 0, WAIT_CYCLES ignored
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   slave_address        byte address
//   slave_read/write     command strobes (both together: write done, read dropped)
//   slave_writedata      write data
//   slave_waitrequest    command not accepted this cycle
//   slave_readdata       read data, qualified by slave_readdatavalid
//   slave_readdatavalid  one pulse per accepted read
//   range_err            sticky error: bad address or read+write together
module avalon_sdram_responder #(
  parameter int          ADDR_WIDTH   = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h6000,
  parameter int          READ_LATENCY = 2,
  parameter int          WAIT_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  output logic        range_err
);

  localparam int          DEPTH = 1 << ADDR_WIDTH;
  localparam logic [31:0] SPAN  = 32'(DEPTH) << 2;

  logic [31:0]           mem [DEPTH];
  logic                  req;
  logic                  accept;
  logic                  rd_push;
  logic                  wr_en;
  logic [31:0]           addr_off;
  logic                  addr_ok;
  logic [ADDR_WIDTH-1:0] addr_idx;

  // Stage that loads the output registers on the next edge
  logic                  feed_v;
  logic                  feed_in;
  logic [ADDR_WIDTH-1:0] feed_idx;

  assign req      = slave_read | slave_write;
  // rst_n gates acceptance so the un-reset memory is never written during reset
  assign accept   = req & ~slave_waitrequest & rst_n;
  assign addr_off = slave_address - BASE_ADDR;
  assign addr_ok  = (slave_address >= BASE_ADDR) && (addr_off < SPAN) &&
                    (slave_address[1:0] == 2'b00);
  assign addr_idx = addr_off[ADDR_WIDTH+1:2];
  assign rd_push  = accept & slave_read & ~slave_write;
  assign wr_en    = accept & slave_write & addr_ok;

`ifdef AVALON_RESPONDER_WAIT_EN
  logic [1:0] wcnt;

  assign slave_waitrequest = req && (wcnt < 2'(WAIT_CYCLES));

  // Counts held-request cycles; any non-waiting cycle (accept or idle) clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 2'd0;
    end else if (slave_waitrequest) begin
      wcnt <= wcnt + 2'd1;
    end else begin
      wcnt <= 2'd0;
    end
  end
`else
  assign slave_waitrequest = 1'b0;
`endif

  // Unsupported configurations (READ_LATENCY outside 1..4, WAIT_CYCLES above 3)
  // show up as this named block in the elaborated hierarchy.
  if (READ_LATENCY < 1 || READ_LATENCY > 4 || WAIT_CYCLES > 3) begin : g_unsupported_params
  end

  // READ_LATENCY-1 shift stages ahead of the output registers
  if (READ_LATENCY == 1) begin : g_lat1
    assign feed_v   = rd_push;
    assign feed_in  = addr_ok;
    assign feed_idx = addr_idx;
  end else begin : g_pipe
    logic [READ_LATENCY-2:0] pv;
    logic [READ_LATENCY-2:0] pin;
    logic [ADDR_WIDTH-1:0]   pidx [READ_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv  <= '0;
        pin <= '0;
        for (int i = 0; i < READ_LATENCY - 1; i++) pidx[i] <= '0;
      end else begin
        pv[0]   <= rd_push;
        pin[0]  <= addr_ok;
        pidx[0] <= addr_idx;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          pv[i]   <= pv[i-1];
          pin[i]  <= pin[i-1];
          pidx[i] <= pidx[i-1];
        end
      end
    end

    assign feed_v   = pv[READ_LATENCY-2];
    assign feed_in  = pin[READ_LATENCY-2];
    assign feed_idx = pidx[READ_LATENCY-2];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_idx] <= slave_writedata;
    end
  end

  // Memory is sampled when the output stage loads, so a write accepted one
  // cycle before a read is always visible to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slave_readdatavalid <= 1'b0;
      slave_readdata      <= 32'd0;
      range_err           <= 1'b0;
    end else begin
      slave_readdatavalid <= feed_v;
      if (feed_v) begin
        slave_readdata <= feed_in ? mem[feed_idx] : 32'hDEADBEEF;
      end
      if ((feed_v && !feed_in) ||
          (accept && slave_write && (!addr_ok || slave_read))) begin
        range_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avalon_sdram_responder.sv
// tb/tb_avalon_sdram_responder.sv - bench for avalon_sdram_responder
module tb_avalon_sdram_responder;

`ifdef AVALON_RESPONDER_WAIT_EN
  localparam int EW = 1;
`else
  localparam int EW = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] slave_address = 32'd0;
  logic        slave_read = 1'b0;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'd0;
  logic        slave_waitrequest;
  logic [31:0] slave_readdata;
  logic        slave_readdatavalid;
  logic        range_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [31:0] rq[$];
  int          rc[$];

  avalon_sdram_responder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .slave_address       (slave_address),
    .slave_read          (slave_read),
    .slave_write         (slave_write),
    .slave_writedata     (slave_writedata),
    .slave_waitrequest   (slave_waitrequest),
    .slave_readdata      (slave_readdata),
    .slave_readdatavalid (slave_readdatavalid),
    .range_err           (range_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) begin
    if (slave_readdatavalid === 1'b1) begin
      rq.push_back(slave_readdata);
      rc.push_back(cyc);
    end
  end

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_resp;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    slave_read  = 1'b0;
    slave_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a command and holds it until accepted; returns acceptance edge number
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output int acc, output int waits);
    slave_read      = rd;
    slave_write     = wr;
    slave_address   = a;
    slave_writedata = d;
    waits = 0;
    acc   = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (slave_waitrequest === 1'b0) begin
        acc = cyc + 1;
        break;
      end
      waits++;
    end
    if (acc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: addr %h never accepted", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string name, input int idx, input logic [31:0] exp, input int acc);
    if (rq.size() > idx) begin
      chk({name, "_data"}, rq[idx], exp);
      chk({name, "_lat"}, 32'(rc[idx] - acc), 32'(1));
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no response, expected %h", name, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_wait"},  {31'd0, slave_waitrequest},   32'd0);
    chk({name, "_valid"}, {31'd0, slave_readdatavalid}, 32'd0);
    chk({name, "_rdata"}, slave_readdata,               32'd0);
    chk({name, "_err"},   {31'd0, range_err},           32'd0);
  endtask

  initial begin
    int acc, waits;
    int a3[3];
    int w3[3];

    vecs[0] = '{1'b0, 1'b1, 32'h6000, 32'h5,    1'b0, 32'h0,    1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h6000, 32'h0,    1'b1, 32'h5,    1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h6000, 32'h7,    1'b0, 32'h0,    1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h6004, 32'h8,    1'b0, 32'h0,    1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h6008, 32'h9,    1'b0, 32'h0,    1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h6008, 32'h0,    1'b1, 32'h9,    1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h6FFC, 32'h1234, 1'b0, 32'h0,    1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'h6FFC, 32'h0,    1'b1, 32'h1234, 1'b0};

    idle(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      rq.delete();
      rc.delete();
      issue(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, acc, waits);
      idle(5);
      chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(EW));
      if (vecs[i].exp_resp) begin
        chk($sformatf("vec%0d_count", i), 32'(rq.size()), 32'd1);
        chk_resp($sformatf("vec%0d", i), 0, vecs[i].exp_data, acc);
      end else begin
        chk($sformatf("vec%0d_count", i), 32'(rq.size()), 32'd0);
      end
      chk($sformatf("vec%0d_err", i), {31'd0, range_err}, {31'd0, vecs[i].exp_err});
    end

    // Back-to-back reads, responses in order
    rq.delete();
    rc.delete();
    issue(1'b1, 1'b0, 32'h6000, 32'h0, a3[0], w3[0]);
    issue(1'b1, 1'b0, 32'h6004, 32'h0, a3[1], w3[1]);
    issue(1'b1, 1'b0, 32'h6008, 32'h0, a3[2], w3[2]);
    idle(5);
    chk("burst_count", 32'(rq.size()), 32'd3);
    chk_resp("burst0", 0, 32'h7, a3[0]);
    chk_resp("burst1", 1, 32'h8, a3[1]);
    chk_resp("burst2", 2, 32'h9, a3[2]);
    chk("burst_waits1", 32'(w3[1]), 32'(EW));
    if (rq.size() == 3) chk("burst_spacing", 32'(rc[2] - rc[1]), 32'(EW + 1));

    // Read immediately after write to same address
    rq.delete();
    rc.delete();
    issue(1'b0, 1'b1, 32'h6004, 32'hA, acc, waits);
    issue(1'b1, 1'b0, 32'h6004, 32'h0, acc, waits);
    idle(5);
    chk_resp("raw", 0, 32'hA, acc);

    // Out-of-range read and write
    chk("err_before_oor", {31'd0, range_err}, 32'd0);
    rq.delete();
    rc.delete();
    issue(1'b1, 1'b0, 32'h5FFC, 32'h0, acc, waits);
    idle(5);
    chk_resp("oor_read", 0, 32'hDEADBEEF, acc);
    chk("oor_read_err", {31'd0, range_err}, 32'd1);
    rq.delete();
    rc.delete();
    issue(1'b0, 1'b1, 32'h7000, 32'h1, acc, waits);
    idle(2);
    issue(1'b1, 1'b0, 32'h6FFC, 32'h0, acc, waits);
    idle(5);
    chk_resp("oor_write_dropped", 0, 32'h1234, acc);
    rq.delete();
    rc.delete();
    issue(1'b1, 1'b0, 32'h6002, 32'h0, acc, waits);
    idle(5);
    chk_resp("misaligned", 0, 32'hDEADBEEF, acc);
    chk("err_sticky", {31'd0, range_err}, 32'd1);

    // Reset clears err, then read+write together
    rst_n = 1'b0;
    idle(2);
    chk("err_cleared", {31'd0, range_err}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    rq.delete();
    rc.delete();
    issue(1'b1, 1'b1, 32'h6010, 32'h3, acc, waits);
    idle(5);
    chk("rw_no_valid", 32'(rq.size()), 32'd0);
    chk("rw_err", {31'd0, range_err}, 32'd1);
    chk("rw_waits", 32'(waits), 32'(EW));
    issue(1'b1, 1'b0, 32'h6010, 32'h0, acc, waits);
    idle(5);
    chk_resp("rw_mem", 0, 32'h3, acc);

    // Reset with reads in flight
    issue(1'b0, 1'b1, 32'h6000, 32'h5, acc, waits);
    idle(2);
    issue(1'b1, 1'b0, 32'h6000, 32'h0, acc, waits);
    issue(1'b1, 1'b0, 32'h6004, 32'h0, acc, waits);
    slave_read  = 1'b0;
    slave_write = 1'b0;
    rst_n = 1'b0;
    rq.delete();
    rc.delete();
    @(negedge clk);
    chk_reset_outputs("midreset");
    idle(3);
    rst_n = 1'b1;
    idle(4);
    chk("flush_no_valid", 32'(rq.size()), 32'd0);
    issue(1'b1, 1'b0, 32'h6000, 32'h0, acc, waits);
    idle(5);
    chk_resp("post_reset_read", 0, 32'h5, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avalon_sdram_responder.md
# avalon_sdram_responder

Avalon-MM slave memory that answers the SDRAM-facing master port of the sorting accelerator. It stores a word-addressed array behind a fixed byte base address. Reads are pipelined with a fixed latency and `readdatavalid`; optional `waitrequest` back-pressure can be inserted. It replaces the behavioural memory in block-level benches and serves as on-chip scratch RAM in FPGA builds.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word-index bits; depth is 2^ADDR_WIDTH words.
- `BASE_ADDR`, 32'h6000: byte address of word 0.
- `READ_LATENCY`, 2: cycles from read acceptance to `readdatavalid`; legal range 1..4.
- `WAIT_CYCLES`, 1: `waitrequest` cycles inserted per command; legal range 0..3.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `slave_address` in 32: byte address.
- `slave_read` in 1: read request.
- `slave_write` in 1: write request.
- `slave_writedata` in 32: write data.
- `slave_waitrequest` out 1: 1 means the command is not accepted this cycle.
- `slave_readdata` out 32: read data, meaningful only when valid.
- `slave_readdatavalid` out 1: one-cycle pulse per accepted read.
- `range_err` out 1: sticky flag for an out-of-range, misaligned or read+write command.

## Operation
- Acceptance: a command is accepted on a rising edge where (`slave_read` or `slave_write`) is 1 and `slave_waitrequest` is 0.
- Back-pressure: a wait counter `wcnt` counts cycles while a command is held.
  - `slave_waitrequest` = request present and `wcnt` < `WAIT_CYCLES` (combinational).
  - `wcnt` increments while waitrequest is 1 and clears to 0 on acceptance.
  - With no request present, `slave_waitrequest` = 0 and `wcnt` holds at 0.
- Decode: the address is in range if `BASE_ADDR` <= addr < `BASE_ADDR` + 4·2^ADDR_WIDTH and addr[1:0] = 0. Word index = (addr − `BASE_ADDR`)[ADDR_WIDTH+1:2].
- Write: an accepted in-range write updates the memory at that edge. An out-of-range write is dropped and sets `range_err`.
- Read: an accepted read pushes {in_range, index} into a READ_LATENCY-deep shift pipeline.
  - At the output stage, `slave_readdata` = mem[index] if in range, else 32'hDEADBEEF.
  - `slave_readdatavalid` = 1 for that stage. An out-of-range read also sets `range_err`.
- Ordering:
  - One read may be accepted per cycle, so up to READ_LATENCY reads are outstanding.
  - Responses return strictly in acceptance order.
  - A read accepted the cycle after a write to the same address returns the new data.
- Read and write asserted together: the write executes, the read is discarded (no valid pulse), and `range_err` is set.
- `range_err` clears only on reset.

## Timing
- Reset values: `slave_waitrequest` 0, `slave_readdatavalid` 0, `slave_readdata` 0, `range_err` 0, `wcnt` 0, all pipeline valid bits 0. Memory contents are not cleared.
- Latency: a read accepted at edge N gives `slave_readdatavalid` = 1 during the cycle following edge N+READ_LATENCY−1. With the default of 2, valid is high in the cycle after edge N+1.
- Throughput:
  - With WAIT_CYCLES = 0, one command per cycle.
  - With WAIT_CYCLES = W, one command per W+1 cycles while the request is held continuously.
- Reset mid-operation: outstanding reads are flushed and no `readdatavalid` is issued for them. `wcnt` clears and a pending write is not performed.
- The master must hold address, data and command stable while `slave_waitrequest` is 1; the block does not check this.

## Configuration
- `AVALON_RESPONDER_WAIT_EN` defined: the `wcnt` logic is compiled in and `WAIT_CYCLES` applies as specified above.
- `AVALON_RESPONDER_WAIT_EN` undefined: `wcnt` is omitted, `slave_waitrequest` is tied to 0, every command is accepted in the cycle it is presented, and `WAIT_CYCLES` is ignored.

## Test plan
All scenarios use the default parameters with `AVALON_RESPONDER_WAIT_EN` defined.
- Reset, write 32'h5 to 0x6000, then read 0x6000: `waitrequest` is 1 for one cycle per command, and `readdatavalid` pulses one cycle after the read's accept edge+1 with data 32'h5.
- Read 0x6000, 0x6004 and 0x6008 after loading 7, 8 and 9: three responses 7, 8, 9 in order, with one valid pulse each. Rebuilt without the macro, the same reads show `waitrequest` always 0 and three consecutive valid cycles.
- Write 32'hA to 0x6004, then read 0x6004 in the next accepted cycle: returns 32'hA.
- Read 0x5FFC, then write 32'h1 to 0x7000:
  - The read returns 32'hDEADBEEF with valid asserted and `range_err` set to 1.
  - The write is dropped; word 0x6FFC is unchanged.
  - `range_err` stays 1 until reset.
- Assert `slave_read` and `slave_write` together at 0x6010 with data 32'h3: memory[4] becomes 3, no valid pulse is issued, and `range_err` is 1.
- Pulse `rst_n` low with two reads outstanding: no `readdatavalid` after reset and all outputs return to reset values. A subsequent read of 0x6000 still returns 32'h5.
